// File: rtl/efpga_cfg_pkg.sv
// efpga_cfg_pkg: shared types and constants for the eFPGA configuration wrapper.
//   cfg_state_t   : loader FSM states
//   MAGIC_DEFAULT : default header tag
//   HDR_*         : header field offsets / width
//   prog_shft_w() : width of the chain-select strobe {valid, select}
package efpga_cfg_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StCheck,
      StDone,
      StErr
   } cfg_state_t;

   localparam logic [15:0] MAGIC_DEFAULT = 16'hEF6A;

   localparam int unsigned HDR_MAGIC_LSB = 16;
   localparam int unsigned HDR_N_LSB     = 0;
   localparam int unsigned HDR_FIELD_W   = 16;

   // Fabric programming port select width is fixed at 5 bits.
   localparam int unsigned PROG_SHFT_PORT_W = 5;

   function automatic int unsigned prog_shft_w(input int unsigned chains);
      return 1 + $clog2(chains);
   endfunction

endpackage

// File: rtl/efpga_cfg_loader.sv
// efpga_cfg_loader: bitstream loader FSM.
//   clk_i, rst_ni : clock, async active-low reset
//   valid_i/ready_o/data_i : host config word stream
//   clear_i       : returns DONE/ERR to IDLE
//   done_o, err_o : registered load result
//   prog_o, prog_shft_o : one-cycle fabric programming strobe
module efpga_cfg_loader
   import efpga_cfg_pkg::*;
#(
   parameter int unsigned CHAINS = 16,
   parameter logic [15:0] MAGIC  = MAGIC_DEFAULT
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        valid_i,
   output logic                        ready_o,
   input  logic [31:0]                 data_i,
   input  logic                        clear_i,
   output logic                        done_o,
   output logic                        err_o,
   output logic [31:0]                 prog_o,
   output logic [PROG_SHFT_PORT_W-1:0] prog_shft_o
);

   localparam int unsigned SelW  = $clog2(CHAINS);
   localparam int unsigned ShftW = prog_shft_w(CHAINS);

   cfg_state_t        state_q;
   logic [15:0]       cnt_q;
   logic [15:0]       n_q;
   logic [31:0]       acc_q;
   logic [31:0]       prog_q;
   logic [ShftW-1:0]  shft_q;
   logic              done_q;
   logic              err_q;

   logic              xfer;
   logic [15:0]       hdr_magic;
   logic [15:0]       hdr_n;

   assign ready_o   = (state_q == StIdle) || (state_q == StLoad) || (state_q == StCheck);
   assign xfer      = valid_i && ready_o;
   assign hdr_magic = data_i[HDR_MAGIC_LSB +: HDR_FIELD_W];
   assign hdr_n     = data_i[HDR_N_LSB +: HDR_FIELD_W];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         n_q     <= '0;
         acc_q   <= '0;
         prog_q  <= '0;
         shft_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         // Programming strobe lasts exactly one cycle.
         prog_q <= '0;
         shft_q <= '0;
         unique case (state_q)
            StIdle: begin
               if (xfer) begin
                  n_q   <= hdr_n;
                  cnt_q <= '0;
                  acc_q <= '0;
                  if (hdr_magic != MAGIC) begin
                     state_q <= StErr;
                     err_q   <= 1'b1;
                  end else if (hdr_n == 16'd0) begin
                     state_q <= StCheck;
                  end else begin
                     state_q <= StLoad;
                  end
               end
            end
            StLoad: begin
               if (xfer) begin
                  prog_q <= data_i;
                  shft_q <= {1'b1, cnt_q[SelW-1:0]};
                  acc_q  <= acc_q ^ data_i;
                  cnt_q  <= cnt_q + 16'd1;
                  if (cnt_q == n_q - 16'd1) begin
                     state_q <= StCheck;
                  end
               end
            end
            StCheck: begin
               if (xfer) begin
                  if (data_i == acc_q) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StErr;
                     err_q   <= 1'b1;
                  end
               end
            end
            StDone, StErr: begin
               if (clear_i) begin
                  state_q <= StIdle;
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
                  acc_q   <= '0;
                  cnt_q   <= '0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign done_o      = done_q;
   assign err_o       = err_q;
   assign prog_o      = prog_q;
   assign prog_shft_o = PROG_SHFT_PORT_W'(shft_q);

endmodule

// File: rtl/fpga.sv
// fpga: behavioural eFPGA fabric with 16 configuration chains.
//   clk, nres     : clock, async active-low reset (clears configuration)
//   prog_i        : configuration word
//   prog_shft     : [4] strobe, [3:0] chain select
//   data_en       : user data strobe; output is zero while low
//   data_in       : 16*V*H bits of user data
//   data_out      : 24*V*H bits, bit i = data_in[i % DinW] ^ chain[(i/32)%16][i%32]
module fpga #(
   parameter int unsigned V = 2,
   parameter int unsigned H = 2
) (
   input  logic                 clk,
   input  logic                 nres,
   input  logic [31:0]          prog_i,
   input  logic [4:0]           prog_shft,
   input  logic                 data_en,
   input  logic [16*V*H-1:0]    data_in,
   output logic [24*V*H-1:0]    data_out
);

   localparam int unsigned DinW  = 16 * V * H;
   localparam int unsigned DoutW = 24 * V * H;

   logic [31:0] chain_q [16];

   always_ff @(posedge clk or negedge nres) begin
      if (!nres) begin
         for (int c = 0; c < 16; c++) begin
            chain_q[c] <= '0;
         end
      end else if (prog_shft[4]) begin
         chain_q[prog_shft[3:0]] <= prog_i;
      end
   end

   for (genvar i = 0; i < DoutW; i++) begin : g_out
      assign data_out[i] = data_en & (data_in[i % DinW] ^ chain_q[(i / 32) % 16][i % 32]);
   end

endmodule

// File: rtl/efpga_cfg_top.sv
// efpga_cfg_top: eFPGA wrapper with configuration loader and gated user datapath.
//   clk, nres             : clock, async active-low reset (also resets fabric)
//   cfg_valid/ready/data  : host bitstream stream
//   cfg_clear             : leave DONE/ERR
//   cfg_done, cfg_err     : load status
//   data_en, data_in      : user data into the fabric (live only once configured)
//   data_out, data_valid  : registered fabric output and qualifier
module efpga_cfg_top
   import efpga_cfg_pkg::*;
#(
   parameter int unsigned V      = 2,
   parameter int unsigned H      = 2,
   parameter int unsigned DIN_W  = 64,
   parameter int unsigned DOUT_W = 96,
   parameter int unsigned CHAINS = 16,
   parameter logic [15:0] MAGIC  = MAGIC_DEFAULT
) (
   input  logic              clk,
   input  logic              nres,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [31:0]       cfg_data,
   input  logic              cfg_clear,
   output logic              cfg_done,
   output logic              cfg_err,
   input  logic              data_en,
   input  logic [DIN_W-1:0]  data_in,
   output logic [DOUT_W-1:0] data_out,
   output logic              data_valid
);

   logic [31:0]                 prog_word;
   logic [PROG_SHFT_PORT_W-1:0] prog_shft;
   logic                        en_gated;
   logic [DOUT_W-1:0]           fab_dout;
   logic [DOUT_W-1:0]           data_out_q;
   logic                        data_valid_q;

   efpga_cfg_loader #(
      .CHAINS (CHAINS),
      .MAGIC  (MAGIC)
   ) u_loader (
      .clk_i       (clk),
      .rst_ni      (nres),
      .valid_i     (cfg_valid),
      .ready_o     (cfg_ready),
      .data_i      (cfg_data),
      .clear_i     (cfg_clear),
      .done_o      (cfg_done),
      .err_o       (cfg_err),
      .prog_o      (prog_word),
      .prog_shft_o (prog_shft)
   );

   assign en_gated = data_en && cfg_done;

   fpga #(
      .V (V),
      .H (H)
   ) u_fpga (
      .clk       (clk),
      .nres      (nres),
      .prog_i    (prog_word),
      .prog_shft (prog_shft),
      .data_en   (en_gated),
      .data_in   (data_in),
      .data_out  (fab_dout)
   );

   always_ff @(posedge clk or negedge nres) begin
      if (!nres) begin
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
      end else begin
         data_out_q   <= cfg_done ? fab_dout : '0;
         data_valid_q <= en_gated;
      end
   end

   // Mask the registered outputs so they drop together with cfg_done on clear.
   assign data_out   = data_out_q & {DOUT_W{cfg_done}};
   assign data_valid = data_valid_q & cfg_done;

endmodule
